fifo_sync_prog: RTL



---
 rtl/fifo_sync_prog.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, sticky overflow/underflow flags and FWFT or registered read.
module fifo_sync_prog #(
  parameter int unsigned DSIZE      = 8,
  parameter int unsigned ASIZE      = 4,
  parameter int unsigned AFULL_LVL  = 12,
  parameter int unsigned AEMPTY_LVL = 4,
  parameter int unsigned FWFT       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned DEPTH = 1 << ASIZE;
  localparam int unsigned PW    = ASIZE + 1;

  localparam logic [PW-1:0] CNT_FULL   = PW'(DEPTH);
  localparam logic [PW-1:0] CNT_AFULL  = PW'(AFULL_LVL);
  localparam logic [PW-1:0] CNT_AEMPTY = PW'(AEMPTY_LVL);

  logic [DSIZE-1:0] mem [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          wfull_q, wfull_d;
  logic          rempty_q, rempty_d;
  logic          walmost_full_q, walmost_full_d;
  logic          ralmost_empty_q, ralmost_empty_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_en, rd_en;

  // Flags are registered copies of what the next count will be, so they
  // change together with count and never depend combinationally on winc/rinc.
  always_comb begin
    wr_en           = winc && !wfull_q;
    rd_en           = rinc && !rempty_q;
    wptr_d          = wptr_q;
    rptr_d          = rptr_q;
    count_d         = count_q;
    overflow_d      = overflow_q | (winc & wfull_q);
    underflow_d     = underflow_q | (rinc & rempty_q);
    if (wr_en) wptr_d = wptr_q + PW'(1);
    if (rd_en) rptr_d = rptr_q + PW'(1);
    if (wr_en && !rd_en)      count_d = count_q + PW'(1);
    else if (rd_en && !wr_en) count_d = count_q - PW'(1);
    wfull_d         = (count_d == CNT_FULL);
    rempty_d        = (count_d == '0);
    walmost_full_d  = (count_d >= CNT_AFULL);
    ralmost_empty_d = (count_d <= CNT_AEMPTY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      count_q         <= '0;
      wfull_q         <= 1'b0;
      rempty_q        <= 1'b1;
      walmost_full_q  <= 1'b0;
      ralmost_empty_q <= 1'b1;
      overflow_q      <= 1'b0;
      underflow_q     <= 1'b0;
    end else begin
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      count_q         <= count_d;
      wfull_q         <= wfull_d;
      rempty_q        <= rempty_d;
      walmost_full_q  <= walmost_full_d;
      ralmost_empty_q <= ralmost_empty_d;
      overflow_q      <= overflow_d;
      underflow_q     <= underflow_d;
    end
  end

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q[ASIZE-1:0]] <= wdata;
  end

  if (FWFT != 0) begin : g_fwft
    assign rdata = mem[rptr_q[ASIZE-1:0]];
  end else begin : g_reg
    logic [DSIZE-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (rd_en) rdata_d = mem[rptr_q[ASIZE-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
  end

  assign wfull         = wfull_q;
  assign rempty        = rempty_q;
  assign walmost_full  = walmost_full_q;
  assign ralmost_empty = ralmost_empty_q;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

endmodule
